adc_capture: RTL and testbench

Capture engine for the dual-channel 12-bit serial ADC Pmod (two data lines, shared chip-select and serial clock): the input counterpart to `dac_control`. Runs conversions at a fixed sample rate, buffers sample pairs in a small FIFO, and serves them to the host as bytes over the FPGA-to-host half of the `comm_fpga_fx2` channel pipe (`chanAddr`, `f2hData`, `f2hValid`, `f2hReady`). Sits beside `dac_control` in the demo top level, clocked from `fx2Clk_in`.

---
 rtl/adc_capture_pkg.sv | 37 +++
 rtl/sample_fifo.sv | 50 +++++
 rtl/adc_capture.sv | 184 ++++++++++++++++++
 tb/tb_adc_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared types and constants for the ADC capture engine
package adc_capture_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int FRAME_BITS = 16;
  localparam int PAIR_W     = 2 * SAMPLE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_QUIET = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BYTE_A_HI = 2'd0,
    BYTE_A_LO = 2'd1,
    BYTE_B_HI = 2'd2,
    BYTE_B_LO = 2'd3
  } byte_idx_t;

  // Pair layout is {A[11:0], B[11:0]}; tag fills the upper nibble of the high bytes.
  function automatic logic [7:0] pick_byte(input logic [1:0]        idx,
                                           input logic [PAIR_W-1:0] pair,
                                           input logic [3:0]        tag);
    logic [7:0] b;
    case (idx)
      BYTE_A_HI: b = {tag, pair[23:20]};
      BYTE_A_LO: b = pair[19:12];
      BYTE_B_HI: b = {tag, pair[11:8]};
      default:   b = pair[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample-pair FIFO with occupancy count
module sample_fifo #(
  parameter int AW = 4,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(2**AW));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - dual-channel serial ADC capture serving bytes on the f2h pipe.
// Define ADC_CAPTURE_TAG_EN to carry a 4-bit frame sequence number in bytes 0 and 2.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter logic [6:0] CHANNEL    = 7'd1,
  parameter int         SCLK_DIV   = 3,
  parameter int         SAMPLE_DIV = 1088,
  parameter int         FIFO_AW    = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [6:0]       chanAddr,
  output logic [7:0]       f2hData,
  output logic             f2hValid,
  input  logic             f2hReady,
  output logic             adc_cs,
  output logic             adc_sclk,
  input  logic             adc_d0,
  input  logic             adc_d1,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_level
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(2 * SCLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);

  if (SAMPLE_DIV < 36 * SCLK_DIV) begin : g_div_check
    $error("adc_capture: SAMPLE_DIV must be at least 36*SCLK_DIV");
  end

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q;
  logic [CW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                phase_q, phase_d;
  logic                tick, last_div, capture, write;
  logic                d0_q, d1_q;
  logic [SAMPLE_W-1:0] sh_a_q, sh_b_q;
  logic [1:0]          idx_q;
  logic                ovf_q, fifo_full, fifo_empty, pop;
  logic [PAIR_W-1:0]   head_pair;
  logic [3:0]          head_tag;

  assign tick     = (tick_q == TW'(SAMPLE_DIV - 1));
  assign last_div = (div_q == CW'(SCLK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tick_q  <= '0;
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      tick_q  <= tick ? '0 : tick_q + TW'(1);
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    capture  = 1'b0;
    write    = 1'b0;
    adc_cs   = 1'b1;
    adc_sclk = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (tick && enable) begin
          state_d = ST_SETUP;
          div_d   = '0;
        end
      end
      ST_SETUP: begin
        adc_cs = 1'b0;
        if (last_div) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        // phase_q=0 is the SCLK low half; its final edge samples the registered input.
        adc_cs   = 1'b0;
        adc_sclk = phase_q;
        if (last_div) begin
          div_d   = '0;
          phase_d = !phase_q;
          if (!phase_q) capture = 1'b1;
          else if (bit_q == BW'(FRAME_BITS - 1)) state_d = ST_WRITE;
          else bit_d = bit_q + BW'(1);
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      ST_WRITE: begin
        write   = 1'b1;
        state_d = ST_QUIET;
        div_d   = '0;
      end
      ST_QUIET: begin
        if (div_q == CW'(2 * SCLK_DIV - 1)) state_d = ST_IDLE;
        else div_d = div_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    d0_q <= adc_d0;
    d1_q <= adc_d1;
  end

  // Only the trailing 12 bits of the frame survive; the leading ones shift out the top.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sh_a_q <= '0;
      sh_b_q <= '0;
    end else if (capture) begin
      sh_a_q <= {sh_a_q[SAMPLE_W-2:0], d0_q};
      sh_b_q <= {sh_b_q[SAMPLE_W-2:0], d1_q};
    end
  end

`ifdef ADC_CAPTURE_TAG_EN
  localparam int FDW = PAIR_W + 4;
  logic [3:0]     seq_q;
  logic [FDW-1:0] fifo_wdata, fifo_rdata;

  always_ff @(posedge clk_in) begin
    if (reset)      seq_q <= '0;
    else if (write) seq_q <= seq_q + 4'd1;
  end

  assign fifo_wdata = {seq_q, sh_a_q, sh_b_q};
  assign head_tag   = fifo_rdata[FDW-1 -: 4];
  assign head_pair  = fifo_rdata[PAIR_W-1:0];
`else
  localparam int FDW = PAIR_W;
  logic [FDW-1:0] fifo_wdata, fifo_rdata;

  assign fifo_wdata = {sh_a_q, sh_b_q};
  assign head_tag   = 4'h0;
  assign head_pair  = fifo_rdata;
`endif

  sample_fifo #(.AW(FIFO_AW), .DW(FDW)) u_fifo (
    .clk_i   (clk_in),
    .reset_i (reset),
    .push_i  (write),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_level)
  );

  assign f2hValid = (chanAddr == CHANNEL) && !fifo_empty;
  assign pop      = f2hValid && f2hReady && (idx_q == BYTE_B_LO);
  assign f2hData  = f2hValid ? pick_byte(idx_q, head_pair, head_tag) : 8'h00;
  assign overflow = ovf_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (f2hValid && f2hReady) idx_q <= idx_q + 2'd1;
      if (write && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - scoreboard bench for adc_capture with a serial ADC model
module tb_adc_capture;
  localparam int SCLK_DIV   = 3;
  localparam int SAMPLE_DIV = 120;
  localparam int FIFO_AW    = 4;
  localparam int DEPTH      = 2**FIFO_AW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [6:0]       chanAddr = 7'd1;
  logic             f2hReady = 1'b0;
  logic             adc_d0 = 1'b0;
  logic             adc_d1 = 1'b0;
  logic [7:0]       f2hData;
  logic             f2hValid, adc_cs, adc_sclk, overflow;
  logic [FIFO_AW:0] fifo_level;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0, last_fall = 0, low_cnt = 0;
  int         m_bits = 0, m_done = 0, m_falls = 0, m_frame = 0;
  logic [3:0] m_seq = 4'h0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b1, fall_valid = 1'b0;
  logic [15:0] wa = 16'h0, wb = 16'h0;

  adc_capture #(
    .CHANNEL(7'd1), .SCLK_DIV(SCLK_DIV), .SAMPLE_DIV(SAMPLE_DIV), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk_in(clk), .reset(reset), .enable(enable), .chanAddr(chanAddr),
    .f2hData(f2hData), .f2hValid(f2hValid), .f2hReady(f2hReady),
    .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_d0(adc_d0), .adc_d1(adc_d1),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] a_of(input int f);
    logic [31:0] t;
    t = 32'hABC + 32'(f) * 32'h135;
    return t[11:0];
  endfunction

  function automatic logic [11:0] b_of(input int f);
    logic [31:0] t;
    t = 32'h123 + 32'(f) * 32'h2F1;
    return t[11:0];
  endfunction

  function automatic int pairs_held();
    return (exp_q.size() + 3) / 4;
  endfunction

  // ADC model: presents the next bit after each SCLK fall; leading nibble must be discarded.
  always @(negedge clk) begin
    logic [3:0] tg;
    if (reset) begin
      m_bits = 0; prev_cs = 1'b1; prev_sclk = 1'b1; fall_valid = 1'b0;
      m_seq = 4'h0; exp_q.delete();
    end else begin
      if (!enable) fall_valid = 1'b0;
      if (prev_cs && !adc_cs) begin
        m_bits = 0; m_falls++; low_cnt = 0;
        wa = {4'h5, a_of(m_frame)};
        wb = {4'hA, b_of(m_frame)};
        if (fall_valid) check("cs_period", cyc - last_fall, SAMPLE_DIV);
        last_fall = cyc; fall_valid = 1'b1;
      end
      if (!adc_cs) low_cnt++;
      if (!adc_cs && prev_sclk && !adc_sclk && m_bits < 16) begin
        adc_d0 = wa[15 - m_bits];
        adc_d1 = wb[15 - m_bits];
        m_bits++;
      end
      if (!prev_cs && adc_cs) begin
        check("cs_low_cycles", low_cnt, 33 * SCLK_DIV);
        check("frame_bits", m_bits, 16);
`ifdef ADC_CAPTURE_TAG_EN
        tg = m_seq;
`else
        tg = 4'h0;
`endif
        if (pairs_held() < DEPTH) begin
          exp_q.push_back({tg, wa[11:8]});
          exp_q.push_back(wa[7:0]);
          exp_q.push_back({tg, wb[11:8]});
          exp_q.push_back(wb[7:0]);
        end
        m_seq++; m_frame++; m_done++;
      end
      prev_cs = adc_cs; prev_sclk = adc_sclk;
    end
  end

  always @(negedge clk) begin
    if (!reset && f2hValid && f2hReady) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("f2h_byte", f2hData, exp_q.pop_front());
    end
  end

  task automatic wait_done(input int n);
    int target = m_done + n;
    for (int i = 0; i < (n + 1) * SAMPLE_DIV + 200 && m_done < target; i++) @(posedge clk);
    #1;
    check("frame_timeout", 32'(m_done >= target), 1);
  endtask

  task automatic wait_bit(input int bitn);
    int i = 0;
    while (!(!adc_cs && m_bits == bitn + 1) && i < 3 * SAMPLE_DIV) begin
      @(posedge clk); #1; i++;
    end
    check("mid_frame_timeout", 32'(i < 3 * SAMPLE_DIV), 1);
  endtask

  task automatic wait_empty(input int budget);
    int i = 0;
    while (fifo_level != 0 && i < budget) begin
      @(posedge clk); #1; i++;
    end
    check("drain_level", fifo_level, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", adc_cs, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_valid", f2hValid, 0);
    check("rst_data", f2hData, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;

    // Streaming with the host always ready.
    f2hReady = 1'b1; enable = 1'b1;
    wait_done(3);
    wait_empty(20);
    check("ovf_idle", overflow, 0);

    // Wrong channel holds the pair.
    chanAddr = 7'd2;
    wait_done(1);
    check("latency_level", fifo_level, 1);
    check("other_chan_valid", f2hValid, 0);
    check("other_chan_data", f2hData, 0);
    repeat (20) @(posedge clk);
    #1;
    check("other_chan_hold", fifo_level, 1);
    chanAddr = 7'd1;
    wait_empty(20);

    // Fill past capacity, then drain.
    f2hReady = 1'b0;
    wait_done(DEPTH + 4);
    check("full_level", fifo_level, DEPTH);
    check("ovf_set", overflow, 1);
    enable = 1'b0; f2hReady = 1'b1;
    wait_empty(200);
    check("sb_after_drain", exp_q.size(), 0);
    enable = 1'b1;
    wait_done(2);
    wait_empty(20);
    check("ovf_sticky", overflow, 1);

    // Enable dropped mid-frame.
    wait_bit(3);
    enable = 1'b0;
    start = m_falls;
    wait_done(1);
    repeat (3 * SAMPLE_DIV) @(posedge clk);
    #1;
    check("no_new_frames", m_falls - start, 0);
    check("enable_drop_level", fifo_level, 0);

    // Reset in the middle of SHIFT bit 7.
    enable = 1'b1;
    wait_bit(7);
    f2hReady = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cs", adc_cs, 1);
    check("midrst_sclk", adc_sclk, 1);
    check("midrst_level", fifo_level, 0);
    check("midrst_overflow", overflow, 0);
    reset = 1'b0;
    wait_done(1);
    check("post_rst_level", fifo_level, 1);
    f2hReady = 1'b1;
    wait_empty(20);
    check("sb_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
